// File: rtl/vga_timing_reducer.sv
// vga_timing_reducer
//   Parametrised VGA timing generator with a registered colour output stage.
//   The counter stage (hc, vc, display_en, frame_start) is built from the counter
//   registers. The output stage (ro/go/bo, hsync, vsync) is registered one clock
//   later, so colour and syncs for a given (hc,vc) leave the block together.
//   Optional feature macro: VGA_REDUCER_DITHER_EN
//     defined   -> 2x2 ordered dither, then reduction from IW to OW bits
//     undefined -> plain truncation to the top OW bits, no adder logic
module vga_timing_reducer #(
    parameter int HACTIVE = 640,
    parameter int HFP     = 16,
    parameter int HSW     = 96,
    parameter int HBP     = 48,
    parameter int VACTIVE = 480,
    parameter int VFP     = 10,
    parameter int VSW     = 2,
    parameter int VBP     = 33,
    parameter int HPOL    = 0,
    parameter int VPOL    = 0,
    parameter int IW      = 6,
    parameter int OW      = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [IW-1:0] r_in,
    input  logic [IW-1:0] g_in,
    input  logic [IW-1:0] b_in,
    output logic [10:0]   hc,
    output logic [10:0]   vc,
    output logic          display_en,
    output logic          frame_start,
    output logic [OW-1:0] ro,
    output logic [OW-1:0] go,
    output logic [OW-1:0] bo,
    output logic          hsync,
    output logic          vsync
);

    // ------------------------------------------------------------------
    // Derived timing constants (counters are fixed at 11 bits)
    // ------------------------------------------------------------------
    localparam int HTOTAL = HACTIVE + HFP + HSW + HBP;
    localparam int VTOTAL = VACTIVE + VFP + VSW + VBP;
    localparam int D      = IW - OW;

    localparam logic [10:0] H_LAST   = 11'(HTOTAL - 1);
    localparam logic [10:0] V_LAST   = 11'(VTOTAL - 1);
    localparam logic [10:0] H_ACT    = 11'(HACTIVE);
    localparam logic [10:0] V_ACT    = 11'(VACTIVE);
    localparam logic [10:0] HS_BEG   = 11'(HACTIVE + HFP);
    localparam logic [10:0] HS_END   = 11'(HACTIVE + HFP + HSW - 1);
    localparam logic [10:0] VS_BEG   = 11'(VACTIVE + VFP);
    localparam logic [10:0] VS_END   = 11'(VACTIVE + VFP + VSW - 1);

    // Active sync levels; the idle level is the complement
    localparam logic HS_ON = (HPOL != 0) ? 1'b1 : 1'b0;
    localparam logic VS_ON = (VPOL != 0) ? 1'b1 : 1'b0;

`ifdef VGA_REDUCER_DITHER_EN
    // Threshold scaling: m<<(D-2) for D>=2, otherwise m>>(2-D)
    localparam int DSHL = (D >= 2) ? (D - 2) : 0;
    localparam int DSHR = (D >= 2) ? 0 : (2 - D);

    // 2x2 ordered-dither matrix indexed by {vc[0], hc[0]}
    function automatic logic [1:0] dither_m(input logic v0, input logic h0);
        case ({v0, h0})
            2'b00:   dither_m = 2'd0;
            2'b01:   dither_m = 2'd2;
            2'b10:   dither_m = 2'd3;
            2'b11:   dither_m = 2'd1;
            default: dither_m = 2'd0;
        endcase
    endfunction

    // Add the scaled threshold at IW+1 bits, saturate on carry, keep the top OW bits
    function automatic logic [OW-1:0] reduce_ch(input logic [IW-1:0] px, input logic [1:0] m);
        logic [IW:0] thr;
        logic [IW:0] sum;
        thr = (IW+1)'(m);
        thr = (thr << DSHL) >> DSHR;
        sum = {1'b0, px} + thr;
        if (sum[IW]) begin
            reduce_ch = {OW{1'b1}};
        end else begin
            reduce_ch = sum[IW-1:D];
        end
    endfunction
`else
    // Plain truncation: keep the most significant OW bits of the channel
    function automatic logic [OW-1:0] reduce_ch(input logic [IW-1:0] px);
        reduce_ch = px[IW-1 -: OW];
    endfunction
`endif

    // ------------------------------------------------------------------
    // Counter stage
    // ------------------------------------------------------------------
    logic [10:0] hc_q;
    logic [10:0] hc_d;
    logic [10:0] vc_q;
    logic [10:0] vc_d;
    logic        h_wrap_s;
    logic        display_en_s;
    logic        frame_start_s;

    // Next-state for the pixel and line counters; vc only moves when hc wraps
    always_comb begin
        h_wrap_s = (hc_q == H_LAST);
        hc_d     = hc_q;
        vc_d     = vc_q;
        if (h_wrap_s) begin
            hc_d = 11'd0;
            if (vc_q == V_LAST) begin
                vc_d = 11'd0;
            end else begin
                vc_d = vc_q + 11'd1;
            end
        end else begin
            hc_d = hc_q + 11'd1;
        end
    end

    // Counter registers; reset parks the raster at the top-left pixel
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hc_q <= 11'd0;
            vc_q <= 11'd0;
        end else begin
            hc_q <= hc_d;
            vc_q <= vc_d;
        end
    end

    assign display_en_s  = (hc_q < H_ACT) && (vc_q < V_ACT);
    assign frame_start_s = (hc_q == 11'd0) && (vc_q == 11'd0);

    // ------------------------------------------------------------------
    // Output stage: colour and sync decode for the pixel at (hc_q, vc_q)
    // ------------------------------------------------------------------
    logic [OW-1:0] ro_q;
    logic [OW-1:0] ro_d;
    logic [OW-1:0] go_q;
    logic [OW-1:0] go_d;
    logic [OW-1:0] bo_q;
    logic [OW-1:0] bo_d;
    logic          hsync_q;
    logic          hsync_d;
    logic          vsync_q;
    logic          vsync_d;

`ifdef VGA_REDUCER_DITHER_EN
    logic [1:0] dm_s;
    assign dm_s = dither_m(vc_q[0], hc_q[0]);
`else
    // Low-order colour bits are discarded by truncation
    if (D > 0) begin : g_drop
        logic unused_low_s;
        assign unused_low_s = ^{r_in[D-1:0], g_in[D-1:0], b_in[D-1:0]};
    end
`endif

    // Sync decode for the current counter position
    always_comb begin
        if ((hc_q >= HS_BEG) && (hc_q <= HS_END)) begin
            hsync_d = HS_ON;
        end else begin
            hsync_d = ~HS_ON;
        end
        if ((vc_q >= VS_BEG) && (vc_q <= VS_END)) begin
            vsync_d = VS_ON;
        end else begin
            vsync_d = ~VS_ON;
        end
    end

    // Colour reduction with blanking outside the active area
    always_comb begin
        ro_d = {OW{1'b0}};
        go_d = {OW{1'b0}};
        bo_d = {OW{1'b0}};
        if (display_en_s) begin
`ifdef VGA_REDUCER_DITHER_EN
            ro_d = reduce_ch(r_in, dm_s);
            go_d = reduce_ch(g_in, dm_s);
            bo_d = reduce_ch(b_in, dm_s);
`else
            ro_d = reduce_ch(r_in);
            go_d = reduce_ch(g_in);
            bo_d = reduce_ch(b_in);
`endif
        end else begin
            ro_d = {OW{1'b0}};
            go_d = {OW{1'b0}};
            bo_d = {OW{1'b0}};
        end
    end

    // Output registers; reset blacks the colour and idles both syncs at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ro_q    <= {OW{1'b0}};
            go_q    <= {OW{1'b0}};
            bo_q    <= {OW{1'b0}};
            hsync_q <= ~HS_ON;
            vsync_q <= ~VS_ON;
        end else begin
            ro_q    <= ro_d;
            go_q    <= go_d;
            bo_q    <= bo_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
        end
    end

    assign hc          = hc_q;
    assign vc          = vc_q;
    assign display_en  = display_en_s;
    assign frame_start = frame_start_s;
    assign ro          = ro_q;
    assign go          = go_q;
    assign bo          = bo_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;

endmodule

// File: tb/tb_vga_timing_reducer.sv
// tb_vga_timing_reducer
//   Instance A: default 640x480 timing, active-low syncs.
//   Instance B: tiny raster (14x8 totals) with active-high syncs, so whole
//   frames fit in a short run.
//   Expectations follow VGA_REDUCER_DITHER_EN when it is defined.
module tb_vga_timing_reducer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a_n, rst_b_n;
    logic [5:0]  r_a, g_a, b_a, r_b, g_b, b_b;
    logic [10:0] hc_a, vc_a, hc_b, vc_b;
    logic        de_a, fs_a, hs_a, vs_a, de_b, fs_b, hs_b, vs_b;
    logic [2:0]  ro_a, go_a, bo_a, ro_b, go_b, bo_b;

    int n_cmp = 0;
    int n_bad = 0;

    vga_timing_reducer u_a (
        .clk(clk), .rst_n(rst_a_n), .r_in(r_a), .g_in(g_a), .b_in(b_a),
        .hc(hc_a), .vc(vc_a), .display_en(de_a), .frame_start(fs_a),
        .ro(ro_a), .go(go_a), .bo(bo_a), .hsync(hs_a), .vsync(vs_a)
    );

    vga_timing_reducer #(
        .HACTIVE(8), .HFP(2), .HSW(3), .HBP(1),
        .VACTIVE(4), .VFP(1), .VSW(2), .VBP(1),
        .HPOL(1), .VPOL(1), .IW(6), .OW(3)
    ) u_b (
        .clk(clk), .rst_n(rst_b_n), .r_in(r_b), .g_in(g_b), .b_in(b_b),
        .hc(hc_b), .vc(vc_b), .display_en(de_b), .frame_start(fs_b),
        .ro(ro_b), .go(go_b), .bo(bo_b), .hsync(hs_b), .vsync(vs_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int ph, pv, eh, ev, first_low, low_cnt, fs_cnt, guard;
        bit p_de, found;

        rst_a_n = 1'b0; rst_b_n = 1'b0;
        r_a = 6'd0; g_a = 6'd0; b_a = 6'd0;
        r_b = 6'd63; g_b = 6'd63; b_b = 6'd63;
        @(negedge clk);
        @(negedge clk);

        // ---------------- reset state ----------------
        chk("a_rst_hc", hc_a, 0);
        chk("a_rst_vc", vc_a, 0);
        chk("a_rst_ro", ro_a, 0);
        chk("a_rst_go", go_a, 0);
        chk("a_rst_bo", bo_a, 0);
        chk("a_rst_hs", hs_a, 1);
        chk("a_rst_vs", vs_a, 1);
        chk("b_rst_hs", hs_b, 0);
        chk("b_rst_vs", vs_b, 0);

        rst_a_n = 1'b1;
        chk("a_rel_de", de_a, 1);
        chk("a_rel_fs", fs_a, 1);

        // ---------------- truncation at (0,0): threshold is 0 here either way ----------------
        r_a = 6'b101101; g_a = 6'b010011; b_a = 6'b111000;
        tick();
        chk("a_trunc_hc", hc_a, 1);
        chk("a_trunc_fs", fs_a, 0);
        chk("a_trunc_ro", ro_a, 3'b101);
        chk("a_trunc_go", go_a, 3'b010);
        chk("a_trunc_bo", bo_a, 3'b111);

        // r=13 at (1,0): truncation gives 1, dither (m=2, t=4) gives 2
        r_a = 6'd13;
        tick();
`ifdef VGA_REDUCER_DITHER_EN
        chk("a_r13_h1", ro_a, 2);
`else
        chk("a_r13_h1", ro_a, 1);
`endif

        // ---------------- line timing and blanking on the default mode ----------------
        r_a = 6'd63; g_a = 6'd63; b_a = 6'd63;
        eh = 2; ev = 0; first_low = -1; low_cnt = 0;
        for (int i = 0; i < 1700; i++) begin
            ph = eh; pv = ev;
            tick();
            if (eh == 799) begin eh = 0; ev = ev + 1; end else eh = eh + 1;
            chk("a_hc", hc_a, eh);
            chk("a_vc", vc_a, ev);
            chk("a_hs", hs_a, (ph >= 656 && ph <= 751) ? 0 : 1);
            chk("a_vs", vs_a, 1);
            chk("a_ro", ro_a, (ph < 640 && pv < 480) ? 7 : 0);
            chk("a_bo", bo_a, (ph < 640 && pv < 480) ? 7 : 0);
            if (hs_a == 1'b0) begin
                low_cnt++;
                if (first_low < 0) first_low = hc_a;
            end
        end
        chk("a_first_hs_low_hc", first_low, 657);
        chk("a_hs_low_cnt", low_cnt, 192);

        // ---------------- mid-frame reset on instance A ----------------
        found = 1'b0;
        for (int i = 0; i < 900 && !found; i++) begin
            tick();
            if (hc_a == 11'd300) found = 1'b1;
        end
        chk("a_reach_300", found, 1);
        chk("a_pre_rst_ro", ro_a, 7);
        rst_a_n = 1'b0;
        #1;
        chk("a_mid_rst_hc", hc_a, 0);
        chk("a_mid_rst_vc", vc_a, 0);
        chk("a_mid_rst_ro", ro_a, 0);
        chk("a_mid_rst_go", go_a, 0);
        chk("a_mid_rst_bo", bo_a, 0);
        chk("a_mid_rst_hs", hs_a, 1);
        @(negedge clk);
        chk("a_hold_hc", hc_a, 0);
        rst_a_n = 1'b1;
        found = 1'b0; guard = 0;
        for (int i = 0; i < 800 && !found; i++) begin
            tick();
            guard++;
            if (hs_a == 1'b0) found = 1'b1;
        end
        chk("a_restart_hs_found", found, 1);
        chk("a_restart_hs_ticks", guard, 657);

        // ---------------- instance B: whole frames, active-high syncs ----------------
        rst_b_n = 1'b1;
        chk("b_rel_de", de_b, 1);
        chk("b_rel_fs", fs_b, 1);
        eh = 0; ev = 0; fs_cnt = 0;
        for (int i = 0; i < 230; i++) begin
            ph = eh; pv = ev;
            p_de = (ph < 8) && (pv < 4);
            tick();
            if (eh == 13) begin eh = 0; ev = (ev == 7) ? 0 : ev + 1; end else eh = eh + 1;
            chk("b_hc", hc_b, eh);
            chk("b_vc", vc_b, ev);
            chk("b_de", de_b, (eh < 8 && ev < 4) ? 1 : 0);
            chk("b_fs", fs_b, (eh == 0 && ev == 0) ? 1 : 0);
            chk("b_hs", hs_b, (ph >= 10 && ph <= 12) ? 1 : 0);
            chk("b_vs", vs_b, (pv >= 5 && pv <= 6) ? 1 : 0);
            chk("b_ro", ro_b, p_de ? 7 : 0);
            chk("b_go", go_b, p_de ? 7 : 0);
            if (fs_b) fs_cnt++;
        end
        chk("b_fs_count", fs_cnt, 2);

        // B now sits at (6,0) of its third frame with ro=7; reset clears it at once
        chk("b_pre_rst_ro", ro_b, 7);
        rst_b_n = 1'b0;
        #1;
        chk("b_mid_rst_hc", hc_b, 0);
        chk("b_mid_rst_ro", ro_b, 0);
        chk("b_mid_rst_hs", hs_b, 0);
        chk("b_mid_rst_vs", vs_b, 0);
        @(negedge clk);
        rst_b_n = 1'b1;
        g_b = 6'd0; b_b = 6'd0;

        // ---------------- dither / truncation vectors on instance B ----------------
        r_b = 6'd13;                       // (0,0)
        tick();
        chk("b_r13_00", ro_b, 1);
        r_b = 6'd13;                       // (1,0)
        tick();
`ifdef VGA_REDUCER_DITHER_EN
        chk("b_r13_10", ro_b, 2);
`else
        chk("b_r13_10", ro_b, 1);
`endif
        r_b = 6'd0;
        for (int i = 0; i < 12; i++) tick();
        chk("b_at_01_hc", hc_b, 0);
        chk("b_at_01_vc", vc_b, 1);
        r_b = 6'd13;                       // (0,1)
        tick();
`ifdef VGA_REDUCER_DITHER_EN
        chk("b_r13_01", ro_b, 2);
`else
        chk("b_r13_01", ro_b, 1);
`endif
        r_b = 6'd13;                       // (1,1)
        tick();
        chk("b_r13_11", ro_b, 1);
        r_b = 6'd0;
        for (int i = 0; i < 26; i++) tick();
        chk("b_at_03_vc", vc_b, 3);
        r_b = 6'd63;                       // (0,3): same matrix cell as (0,1)
        tick();
        chk("b_r63_sat", ro_b, 7);
        r_b = 6'd45;                       // (1,3): 101101
        tick();
`ifdef VGA_REDUCER_DITHER_EN
        chk("b_r45_13", ro_b, 5);
`else
        chk("b_r45_13", ro_b, 5);
`endif
        r_b = 6'd63;                       // (2,3) active, then hc=8 blanked
        tick();
        chk("b_r63_act", ro_b, 7);
        for (int i = 0; i < 6; i++) tick();
        chk("b_blank_hc", ro_b, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
